fm_wm_row_producer: RTL

Sequential producer for the FM×WM stage of the GCN datapath. It computes one row of the feature-matrix × weight-matrix product per pass: it fetches feature row r and every weight row k from synchronous-read memories and accumulates WEIGHT_COLS dot products. It then writes the finished row into the adjacency-multiply stage's FM×WM buffer through a one-cycle `enable`/`write_row`/`fm_wm_vector` strobe. It is the write side of that buffer interface.

---
 rtl/fm_wm_row_producer_pkg.sv | 12 +
 rtl/fm_wm_row_producer_if.sv | 36 +++
 rtl/fm_wm_row_producer_mac_lane.sv | 42 ++++
 rtl/fm_wm_row_producer.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/fm_wm_row_producer_pkg.sv
// Shared definitions for the FM x WM row producer: controller state encoding.
package gcn_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_MAC   = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/fm_wm_row_producer_if.sv
// Bundle of the producer's control, memory-read and buffer-write signals.
// The master side is the producer; the slave side is the surrounding system
// (memories, FM x WM buffer and whoever issues start).
interface fm_wm_row_producer_if #(
    parameter int NUM_OF_NODES          = 6,
    parameter int FEATURE_COLS          = 4,
    parameter int WEIGHT_COLS           = 3,
    parameter int FEATURE_WIDTH         = 5,
    parameter int WEIGHT_WIDTH          = 5,
    parameter int DOT_PROD_WIDTH        = 16,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(NUM_OF_NODES),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(FEATURE_COLS)
);
    logic                                   start;
    logic                                   busy;
    logic                                   done;
    logic [COUNTER_FEATURE_WIDTH-1:0]       read_feature_address;
    logic [FEATURE_COLS*FEATURE_WIDTH-1:0]  feature_row;
    logic [COUNTER_WEIGHT_WIDTH-1:0]        read_weight_address;
    logic [WEIGHT_COLS*WEIGHT_WIDTH-1:0]    weight_row;
    logic                                   enable;
    logic [COUNTER_FEATURE_WIDTH-1:0]       write_row;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  fm_wm_vector;

    modport master (
        input  start, feature_row, weight_row,
        output busy, done, read_feature_address, read_weight_address,
               enable, write_row, fm_wm_vector
    );

    modport slave (
        output start, feature_row, weight_row,
        input  busy, done, read_feature_address, read_weight_address,
               enable, write_row, fm_wm_vector
    );
endinterface

// File: rtl/fm_wm_row_producer_mac_lane.sv
// One output column of the FM x WM row: an unsigned multiply-accumulate lane.
// Products are zero-extended (or truncated) to the accumulator width and the
// running sum wraps modulo 2^DOT_PROD_WIDTH. Clear wins over accumulate.
module fm_wm_mac_lane #(
    parameter int FEATURE_WIDTH  = 5,
    parameter int WEIGHT_WIDTH   = 5,
    parameter int DOT_PROD_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      clear,
    input  logic                      acc_en,
    input  logic [FEATURE_WIDTH-1:0]  feature_elem,
    input  logic [WEIGHT_WIDTH-1:0]   weight_elem,
    output logic [DOT_PROD_WIDTH-1:0] acc
);
    logic [FEATURE_WIDTH+WEIGHT_WIDTH-1:0] product;
    logic [DOT_PROD_WIDTH-1:0]             acc_q;
    logic [DOT_PROD_WIDTH-1:0]             acc_d;

    // Next accumulator value: clear, add one product, or hold.
    always_comb begin
        product = feature_elem * weight_elem;
        acc_d   = acc_q;
        if (clear) begin
            acc_d = '0;
        end else if (acc_en) begin
            acc_d = acc_q + DOT_PROD_WIDTH'(product);
        end
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

    assign acc = acc_q;
endmodule

// File: rtl/fm_wm_row_producer.sv
// FM x WM row producer: for each feature row r it streams weight rows
// W[0..FEATURE_COLS-1] out of a one-cycle-latency memory, accumulates
// WEIGHT_COLS dot products and writes the finished row into the FM x WM
// buffer with a single enable strobe. All rows of a pass are produced
// back to back, followed by a one-cycle done pulse.
module fm_wm_row_producer
    import gcn_pkg::*;
#(
    parameter int NUM_OF_NODES          = 6,
    parameter int FEATURE_COLS          = 4,
    parameter int WEIGHT_COLS           = 3,
    parameter int FEATURE_WIDTH         = 5,
    parameter int WEIGHT_WIDTH          = 5,
    parameter int DOT_PROD_WIDTH        = 16,
    parameter int COUNTER_FEATURE_WIDTH = $clog2(NUM_OF_NODES),
    parameter int COUNTER_WEIGHT_WIDTH  = $clog2(FEATURE_COLS)
) (
    input  logic                   clk,
    input  logic                   reset,
    fm_wm_row_producer_if.master   bus
);
    localparam logic [COUNTER_FEATURE_WIDTH-1:0] R_LAST = COUNTER_FEATURE_WIDTH'(NUM_OF_NODES - 1);
    localparam logic [COUNTER_WEIGHT_WIDTH-1:0]  K_LAST = COUNTER_WEIGHT_WIDTH'(FEATURE_COLS - 1);

    state_e                                 state_q, state_d;
    logic [COUNTER_FEATURE_WIDTH-1:0]       r_q, r_d;
    logic [COUNTER_WEIGHT_WIDTH-1:0]        k_q, k_d;

    logic                                   acc_clear;
    logic                                   acc_en;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  acc_flat;
    logic [FEATURE_WIDTH-1:0]               feature_elem;

    logic [COUNTER_FEATURE_WIDTH-1:0]       feat_addr;
    logic [COUNTER_WEIGHT_WIDTH-1:0]        wgt_addr;
    logic                                   wr_enable;
    logic [COUNTER_FEATURE_WIDTH-1:0]       wr_row;
    logic [WEIGHT_COLS*DOT_PROD_WIDTH-1:0]  wr_vector;
    logic                                   done_pulse;

    // Feature element k is shared by every lane; each lane owns one weight column.
    assign feature_elem = bus.feature_row[k_q*FEATURE_WIDTH +: FEATURE_WIDTH];

    for (genvar j = 0; j < WEIGHT_COLS; j++) begin : g_lane
        fm_wm_mac_lane #(
            .FEATURE_WIDTH  (FEATURE_WIDTH),
            .WEIGHT_WIDTH   (WEIGHT_WIDTH),
            .DOT_PROD_WIDTH (DOT_PROD_WIDTH)
        ) u_lane (
            .clk          (clk),
            .reset        (reset),
            .clear        (acc_clear),
            .acc_en       (acc_en),
            .feature_elem (feature_elem),
            .weight_elem  (bus.weight_row[j*WEIGHT_WIDTH +: WEIGHT_WIDTH]),
            .acc          (acc_flat[j*DOT_PROD_WIDTH +: DOT_PROD_WIDTH])
        );
    end

    // Next state, row/weight counters, memory addresses and write strobe.
    always_comb begin
        state_d    = state_q;
        r_d        = r_q;
        k_d        = k_q;
        acc_clear  = 1'b0;
        acc_en     = 1'b0;
        feat_addr  = '0;
        wgt_addr   = '0;
        wr_enable  = 1'b0;
        wr_row     = '0;
        wr_vector  = '0;
        done_pulse = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d = ST_LOAD;
                    r_d     = '0;
                    k_d     = '0;
                end
            end
            ST_LOAD: begin
                // Prime both memories so W[0] and feature row r arrive in the first MAC cycle.
                feat_addr = r_q;
                wgt_addr  = '0;
                state_d   = ST_MAC;
            end
            ST_MAC: begin
                // Feature address held so the row stays valid; weight address runs one ahead.
                feat_addr = r_q;
                wgt_addr  = (k_q == K_LAST) ? K_LAST : k_q + 1'b1;
                acc_en    = 1'b1;
                if (k_q == K_LAST) begin
                    state_d = ST_WRITE;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            ST_WRITE: begin
                wr_enable = 1'b1;
                wr_row    = r_q;
                wr_vector = acc_flat;
                acc_clear = 1'b1;
                k_d       = '0;
                if (r_q == R_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    r_d     = r_q + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_DONE: begin
                done_pulse = 1'b1;
                state_d    = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Controller state and counters.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            r_q     <= '0;
            k_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            k_q     <= k_d;
        end
    end

    assign bus.read_feature_address = feat_addr;
    assign bus.read_weight_address  = wgt_addr;
    assign bus.enable               = wr_enable;
    assign bus.write_row            = wr_row;
    assign bus.fm_wm_vector         = wr_vector;
    assign bus.done                 = done_pulse;
    assign bus.busy                 = (state_q != ST_IDLE);
endmodule
